// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: 1-cycle fetch latency, one response per cycle, held stable under resp_ready backpressure.
// A word-serial loader fills the array from word 0; req_ready stays low while loading or draining.
module imem_fetch_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [63:0] BASE_ADDR   = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [63:0] req_addr,
  output logic        req_ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_instr,
  output logic        resp_err,
  input  logic        ld_en,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        ld_done
);
  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [AW:0] LAST_PTR = (AW+1)'(DEPTH_WORDS - 1);
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [63:0] SPAN     = 64'(DEPTH_WORDS) << 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {LOAD, SERVE, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [AW:0] ptr_q, ptr_d;
  logic [AW:0] loaded_cnt_q, loaded_cnt_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_instr_q, resp_instr_d;
  logic        resp_err_q, resp_err_d;
  logic        ld_done_q, ld_done_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic [63:0] off;
  logic [61:0] idx;
  logic        accept;
  logic        mem_we;

  // Addresses below BASE_ADDR wrap to huge offsets and land in the out-of-range case.
  assign off = req_addr - BASE_ADDR;
  assign idx = off[63:2];

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    loaded_cnt_d = loaded_cnt_q;
    resp_valid_d = resp_valid_q;
    resp_instr_d = resp_instr_q;
    resp_err_d   = resp_err_q;
    ld_done_d    = 1'b0;
    req_ready    = 1'b0;
    ld_ready     = 1'b0;
    mem_we       = 1'b0;
    accept       = 1'b0;

    case (state_q)
      LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          mem_we = 1'b1;
          ptr_d  = ptr_q + PTR_ONE;
          if (ld_last || (ptr_q == LAST_PTR)) begin
            loaded_cnt_d = ptr_q + PTR_ONE;
            ptr_d        = '0;
            ld_done_d    = 1'b1;
            state_d      = SERVE;
          end
        end
      end
      SERVE: begin
        // ld_en wins over a simultaneous request.
        req_ready = !ld_en && (!resp_valid_q || resp_ready);
        if (ld_en) begin
          state_d = (resp_valid_q && !resp_ready) ? DRAIN : LOAD;
        end
      end
      DRAIN: begin
        if (!resp_valid_q || resp_ready) begin
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase

    accept = req_valid && req_ready;
    if (accept) begin
      resp_valid_d = 1'b1;
      if (off[1:0] != 2'b00 || off >= SPAN) begin
        resp_instr_d = NOP;
        resp_err_d   = 1'b1;
      end else if (idx >= 62'(loaded_cnt_q)) begin
        resp_instr_d = NOP;
        resp_err_d   = 1'b0;
      end else begin
        resp_instr_d = mem_q[idx[AW-1:0]];
        resp_err_d   = 1'b0;
      end
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= LOAD;
      ptr_q        <= '0;
      loaded_cnt_q <= '0;
      resp_valid_q <= 1'b0;
      resp_instr_q <= NOP;
      resp_err_q   <= 1'b0;
      ld_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      loaded_cnt_q <= loaded_cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_instr_q <= resp_instr_d;
      resp_err_q   <= resp_err_d;
      ld_done_q    <= ld_done_d;
    end
  end

  // Array contents survive reset; loaded_cnt alone decides what is readable.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[ptr_q[AW-1:0]] <= ld_data;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_instr = resp_instr_q;
  assign resp_err   = resp_err_q;
  assign ld_done    = ld_done_q;

endmodule
